memb_port_arbiter: RTL and testbench

- Shares port B of the dual-port instruction/data memory between two requesters:
  - the host interface (setup_mem/verify_mem load and readback path);
  - the core's memory stage (load/store).
- Port A stays dedicated to instruction fetch.
- The block arbitrates per cycle with round-robin fairness, supports a host lock for bulk setup, registers the memory command and returns tagged read data two cycles after grant.
- It drives core_stall so the pipeline holds while the core is not granted.

---
 rtl/memb_port_arbiter_if.sv | 58 +++++
 rtl/memb_port_arbiter.sv | 99 +++++++++
 tb/tb_memb_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/memb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memb_port_arbiter_if
// Brief    : Host / core / memory port-B signal bundle for memb_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memb_port_arbiter_if #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                      en;
    logic                      host_lock;

    logic                      host_req;
    logic                      host_we;
    logic [MEM_ADDR_WIDTH-1:0] host_addr;
    logic [DATAPATH_WIDTH-1:0] host_wdata;
    logic                      host_gnt;
    logic                      host_rvalid;
    logic [DATAPATH_WIDTH-1:0] host_rdata;

    logic                      core_req;
    logic                      core_we;
    logic [MEM_ADDR_WIDTH-1:0] core_addr;
    logic [DATAPATH_WIDTH-1:0] core_wdata;
    logic                      core_gnt;
    logic                      core_rvalid;
    logic [DATAPATH_WIDTH-1:0] core_rdata;
    logic                      core_stall;

    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATAPATH_WIDTH-1:0] mem_din;
    logic                      mem_we;
    logic [DATAPATH_WIDTH-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  en, host_lock,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

    // Requester / memory side
    modport master (
        output en, host_lock,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/memb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memb_port_arbiter
// Brief    : Round-robin arbiter sharing memory port B between host and core,
//            with host lock, registered command and tagged 2-cycle read return.
// Revision : 1.0 - initial release
// ============================================================================
module memb_port_arbiter #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    memb_port_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        OWNER_CORE = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

    owner_e                    r_last_gnt;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATAPATH_WIDTH-1:0] r_mem_din;
    logic                      r_mem_we;
    logic                      r_tag_valid;
    logic                      r_tag_host;
    logic                      r_host_rvalid;
    logic                      r_core_rvalid;
    logic [DATAPATH_WIDTH-1:0] r_host_rdata;
    logic [DATAPATH_WIDTH-1:0] r_core_rdata;

    logic                      w_active;
    logic                      w_host_gnt;
    logic                      w_core_gnt;
    logic                      w_any_gnt;
    logic                      w_gnt_we;
    logic [MEM_ADDR_WIDTH-1:0] w_gnt_addr;
    logic [DATAPATH_WIDTH-1:0] w_gnt_wdata;

    // Contention goes to whoever did not win last; a lock hands the port to the host.
    always_comb begin
        w_active    = bus.en & reset;
        w_host_gnt  = w_active & bus.host_req &
                      (bus.host_lock | ~bus.core_req | (r_last_gnt == OWNER_CORE));
        w_core_gnt  = w_active & bus.core_req & ~bus.host_lock &
                      (~bus.host_req | (r_last_gnt == OWNER_HOST));
        w_any_gnt   = w_host_gnt | w_core_gnt;
        w_gnt_we    = w_host_gnt ? bus.host_we    : bus.core_we;
        w_gnt_addr  = w_host_gnt ? bus.host_addr  : bus.core_addr;
        w_gnt_wdata = w_host_gnt ? bus.host_wdata : bus.core_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_gnt    <= OWNER_HOST;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_mem_we      <= 1'b0;
            r_tag_valid   <= 1'b0;
            r_tag_host    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_core_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_core_rdata  <= '0;
        end else begin
            if (w_any_gnt) begin
                r_last_gnt <= w_host_gnt ? OWNER_HOST : OWNER_CORE;
                r_mem_addr <= w_gnt_addr;
                r_mem_din  <= w_gnt_wdata;
            end
            r_mem_we      <= w_any_gnt & w_gnt_we;

            // Stage 1 tags the command now on port B; stage 2 is the rvalid itself.
            r_tag_valid   <= w_any_gnt & ~w_gnt_we;
            r_tag_host    <= w_host_gnt;
            r_host_rvalid <= r_tag_valid &  r_tag_host;
            r_core_rvalid <= r_tag_valid & ~r_tag_host;
            if (r_tag_valid & r_tag_host) begin
                r_host_rdata <= bus.mem_dout;
            end
            if (r_tag_valid & ~r_tag_host) begin
                r_core_rdata <= bus.mem_dout;
            end
        end
    end

    assign bus.host_gnt    = w_host_gnt;
    assign bus.core_gnt    = w_core_gnt;
    assign bus.core_stall  = bus.core_req & ~w_core_gnt;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.mem_we      = r_mem_we;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.core_rvalid = r_core_rvalid;
    assign bus.core_rdata  = r_core_rdata;

endmodule
`default_nettype wire

// File: tb/tb_memb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memb_port_arbiter
// Brief    : Directed + random bench for memb_port_arbiter against a
//            grant-order transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memb_port_arbiter;
    localparam int c_DW = 64;
    localparam int c_AW = 10;

    logic clk;
    logic reset;

    memb_port_arbiter_if #(.DATAPATH_WIDTH(c_DW), .MEM_ADDR_WIDTH(c_AW)) bus ();

    memb_port_arbiter #(.DATAPATH_WIDTH(c_DW), .MEM_ADDR_WIDTH(c_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B memory: address registered by the arbiter, data available in the same cycle.
    logic [c_DW-1:0] bram [0:(1<<c_AW)-1];
    assign bus.mem_dout = bram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;

    // Transaction-level reference model
    typedef struct {
        int              due;
        bit              is_host;
        logic [c_DW-1:0] data;
    } rd_t;

    logic [c_DW-1:0] ref_mem [0:(1<<c_AW)-1];
    rd_t             rq[$];
    bit              m_last_host;
    logic [c_AW-1:0] m_addr;
    logic [c_DW-1:0] m_din;
    bit              m_we;
    logic [c_DW-1:0] m_hrd, m_crd;
    bit              wp_valid;
    logic [c_AW-1:0] wp_addr;
    logic [c_DW-1:0] wp_data;
    int              cyc;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_last_host = 1'b1;
        m_addr      = '0;
        m_din       = '0;
        m_we        = 1'b0;
        m_hrd       = '0;
        m_crd       = '0;
        wp_valid    = 1'b0;
    endtask

    task automatic set_in(input bit en, input bit lock,
                          input bit hreq, input bit hwe, input int haddr, input logic [c_DW-1:0] hwd,
                          input bit creq, input bit cwe, input int caddr, input logic [c_DW-1:0] cwd);
        bus.en         = en;
        bus.host_lock  = lock;
        bus.host_req   = hreq;
        bus.host_we    = hwe;
        bus.host_addr  = c_AW'(haddr);
        bus.host_wdata = hwd;
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = c_AW'(caddr);
        bus.core_wdata = cwd;
    endtask

    task automatic idle();
        set_in(1, 0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit              eh, ec, exp_hrv, exp_crv, we;
        logic [c_AW-1:0] a;
        @(negedge clk);
        if (!reset) model_reset();
        eh = reset && bus.en && bus.host_req &&
             (bus.host_lock || !bus.core_req || !m_last_host);
        ec = reset && bus.en && bus.core_req && !bus.host_lock &&
             (!bus.host_req || m_last_host);
        exp_hrv = 0;
        exp_crv = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].is_host) begin exp_hrv = 1; m_hrd = rq[0].data; end
            else               begin exp_crv = 1; m_crd = rq[0].data; end
            void'(rq.pop_front());
        end
        check("host_gnt",    c_DW'(bus.host_gnt),    c_DW'(eh));
        check("core_gnt",    c_DW'(bus.core_gnt),    c_DW'(ec));
        check("core_stall",  c_DW'(bus.core_stall),  c_DW'(bus.core_req && !ec));
        check("mem_we",      c_DW'(bus.mem_we),      c_DW'(m_we));
        check("mem_addr",    c_DW'(bus.mem_addr),    c_DW'(m_addr));
        check("mem_din",     bus.mem_din,            m_din);
        check("host_rvalid", c_DW'(bus.host_rvalid), c_DW'(exp_hrv));
        check("core_rvalid", c_DW'(bus.core_rvalid), c_DW'(exp_crv));
        check("host_rdata",  bus.host_rdata,         m_hrd);
        check("core_rdata",  bus.core_rdata,         m_crd);
        @(posedge clk);
        if (reset) begin
            if (wp_valid) ref_mem[wp_addr] = wp_data;
            wp_valid = 0;
            m_we     = 0;
            if (eh || ec) begin
                m_last_host = eh;
                a      = eh ? bus.host_addr  : bus.core_addr;
                m_addr = a;
                m_din  = eh ? bus.host_wdata : bus.core_wdata;
                we     = eh ? bus.host_we    : bus.core_we;
                m_we   = we;
                if (we) begin
                    wp_valid = 1; wp_addr = a; wp_data = m_din;
                end else begin
                    rq.push_back('{due: cyc + 2, is_host: eh, data: ref_mem[a]});
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b1;
    endtask

    int lock_left;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < (1 << c_AW); i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        idle();
        reset = 1'b0;
        do_reset(3);

        // Host write then readback
        set_in(1, 0, 1, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, '0); cycle();
        idle(); cycle(); cycle();
        set_in(1, 0, 1, 0, 5, '0, 0, 0, 0, '0); cycle();
        idle(); cycle(); cycle(); cycle();

        // Continuous contention from reset
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 1, 0, 5, '0, 1, 0, i, '0); cycle();
        end
        idle(); cycle(); cycle();

        // Host lock, then release with both requesting
        for (int i = 0; i < 8; i++) begin
            set_in(1, 1, 1, 1, 16 + i, {32'hA5A5_0000, 32'(i)}, 1, 0, 3, '0); cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 16 + i, '0, 1, 0, 20 + i, '0); cycle();
        end
        idle(); cycle(); cycle();

        // Core read, then en drops with core still requesting
        set_in(1, 0, 0, 0, 0, '0, 1, 0, 17, '0); cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 0, 18, '0, 1, 0, 19, '0); cycle();
        end
        idle(); cycle();

        // Core read, then reset in the following cycle
        set_in(1, 0, 0, 0, 0, '0, 1, 0, 16, '0); cycle();
        set_in(1, 0, 1, 0, 17, '0, 1, 0, 18, '0);
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 19, '0, 1, 0, 20, '0); cycle();
        end
        idle(); cycle(); cycle();

        // Random traffic on a small address window to provoke hazards
        lock_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (lock_left == 0 && $urandom_range(0, 19) == 0) lock_left = $urandom_range(1, 6);
            set_in($urandom_range(0, 9) != 0, lock_left != 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), {$urandom, $urandom},
                   $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), {$urandom, $urandom});
            if (lock_left != 0) lock_left--;
            cycle();
        end
        idle(); cycle(); cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
